serial_crc_checker: RTL and testbench

- Receive-side counterpart of the serial CRC generator for generator polynomial G(y) = 1 + y + y^8 + y^9.
- Accepts a serial codeword MSB first: DATA_W message bits followed by CRC_W check bits.
- Divides the codeword by G with an LFSR, recovers the message word and reports the syndrome plus a pass/fail flag.
- Sits at the link receive end, downstream of the deserialiser/bit-sync.

---
 rtl/serial_crc_checker.sv | 116 +++++++++++
 tb/tb_serial_crc_checker.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/serial_crc_checker.sv
// Serial CRC checker for G(y) = 1 + y + y^8 + y^9: divides an MSB-first codeword
// by G, recovers the message word and reports the syndrome with a pass flag.
module serial_crc_checker #(
   parameter int unsigned           DATA_W = 10,
   parameter int unsigned           CRC_W  = 9,
   parameter logic [CRC_W-1:0]      POLY   = 9'h103
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              bit_valid,
   input  logic              bit_in,
   output logic              busy,
   output logic              done,
   output logic              crc_ok,
   output logic [CRC_W-1:0]  syndrome,
   output logic [DATA_W-1:0] data_out
);

   localparam int unsigned FRAME_W = DATA_W + CRC_W;
   localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RECV,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [CRC_W-1:0]    lfsr_q, lfsr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   sr_q, sr_d;
   logic [CRC_W-1:0]    syn_q, syn_d;
   logic                ok_q, ok_d;
   logic [DATA_W-1:0]   data_q, data_d;

   logic                accept;
   logic                last_bit;
   logic                restart;
   logic [CRC_W-1:0]    lfsr_step;

   assign accept    = (state_q == S_RECV) && bit_valid && !start;
   assign last_bit  = (cnt_q == CNT_W'(FRAME_W - 1));
   assign restart   = start && ((state_q == S_IDLE) || (state_q == S_RECV));
   assign lfsr_step = {lfsr_q[CRC_W-2:0], bit_in} ^ (lfsr_q[CRC_W-1] ? POLY : '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         lfsr_q  <= '0;
         cnt_q   <= '0;
         sr_q    <= '0;
         syn_q   <= '0;
         ok_q    <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
         syn_q   <= syn_d;
         ok_q    <= ok_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start) state_d = S_RECV;
         S_RECV: begin
            if (start)                   state_d = S_RECV;
            else if (accept && last_bit) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Results are captured on the final accepted bit so they are already valid
   // during the cycle that done is high.
   always_comb begin
      lfsr_d = lfsr_q;
      cnt_d  = cnt_q;
      sr_d   = sr_q;
      syn_d  = syn_q;
      ok_d   = ok_q;
      data_d = data_q;
      if (restart) begin
         lfsr_d = '0;
         cnt_d  = '0;
         sr_d   = '0;
         ok_d   = 1'b0;
      end else if (accept) begin
         lfsr_d = lfsr_step;
         cnt_d  = cnt_q + CNT_W'(1);
         if (cnt_q < CNT_W'(DATA_W)) begin
            sr_d = {sr_q[DATA_W-2:0], bit_in};
         end
         if (last_bit) begin
            syn_d  = lfsr_step;
            ok_d   = (lfsr_step == '0);
            data_d = sr_q;
         end
      end
   end

   always_comb begin
      busy     = (state_q == S_RECV);
      done     = (state_q == S_DONE);
      crc_ok   = ok_q;
      syndrome = syn_q;
      data_out = data_q;
   end

endmodule

// File: tb/tb_serial_crc_checker.sv
// Self-checking bench for serial_crc_checker: directed vector table, multi-cycle
// corner sequences and random frames against a polynomial long-division model.
module tb_serial_crc_checker;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       bit_valid;
   logic       bit_in;
   logic       busy;
   logic       done;
   logic       crc_ok;
   logic [8:0] syndrome;
   logic [9:0] data_out;

   int checks = 0;
   int errors = 0;

   serial_crc_checker #(
      .DATA_W (10),
      .CRC_W  (9),
      .POLY   (9'h103)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .bit_valid (bit_valid),
      .bit_in    (bit_in),
      .busy      (busy),
      .done      (done),
      .crc_ok    (crc_ok),
      .syndrome  (syndrome),
      .data_out  (data_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [18:0] cw;
      logic [8:0]  syn;
      logic        ok;
      logic [9:0]  data;
      int          gap;
      string       name;
   } vec_t;

   vec_t vecs[5];

   // Remainder of the codeword polynomial divided by y^9 + y^8 + y + 1.
   function automatic logic [8:0] ref_mod(input logic [18:0] cw);
      logic [18:0] r;
      logic [18:0] g;
      r = cw;
      g = 19'h303;
      for (int i = 18; i >= 9; i--) begin
         if (r[i]) r = r ^ (g << (i - 9));
      end
      return r[8:0];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic shift_bits(input logic [18:0] cw, input int n, input int gap, input string tag);
      int early = 0;
      for (int i = 18; i > 18 - n; i--) begin
         if (gap == 1) begin
            bit_valid = 1'b0; bit_in = ~cw[i]; tick();
            if (done) early++;
         end else if (gap == 2) begin
            repeat ($urandom_range(0, 3)) begin
               bit_valid = 1'b0; bit_in = 1'($urandom_range(0, 1)); tick();
               if (done) early++;
            end
         end
         bit_valid = 1'b1; bit_in = cw[i]; tick();
         if (done && i > 0) early++;
      end
      check({tag, " early_done"}, early, 0);
   endtask

   task automatic run_frame(input logic [18:0] cw, input logic [8:0] esyn, input logic eok,
                            input logic [9:0] edata, input int gap, input string tag);
      start = 1'b1; bit_valid = 1'($urandom_range(0, 1)); bit_in = ~cw[18]; tick();
      start = 1'b0;
      check({tag, " busy_after_start"}, busy, 1);
      shift_bits(cw, 19, gap, tag);
      check({tag, " done"}, done, 1);
      check({tag, " busy_in_done"}, busy, 0);
      check({tag, " syndrome"}, syndrome, esyn);
      check({tag, " crc_ok"}, crc_ok, eok);
      check({tag, " data_out"}, data_out, edata);
      bit_valid = 1'b0; tick();
      check({tag, " done_one_cycle"}, done, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [8:0]  ms;
      logic [9:0]  md;
      logic [18:0] cw;
      int          busy_seen;

      vecs[0] = '{19'b1100000011_000000000, 9'h000, 1'b1, 10'b1100000011, 0, "zero_crc"};
      vecs[1] = '{19'b0000000001_100000011, 9'h000, 1'b1, 10'b0000000001, 0, "nonzero_crc"};
      vecs[2] = '{19'b1100000011_000000001, 9'h001, 1'b0, 10'b1100000011, 0, "lsb_error"};
      vecs[3] = '{19'b0100000011_000000000, 9'h004, 1'b0, 10'b0100000011, 0, "msb_error"};
      vecs[4] = '{19'b1100000011_000000000, 9'h000, 1'b1, 10'b1100000011, 1, "gapped"};

      reset = 1'b1; start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
      tick(); tick();
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset crc_ok", crc_ok, 0);
      check("reset syndrome", syndrome, 0);
      check("reset data_out", data_out, 0);
      reset = 1'b0;
      tick();

      foreach (vecs[k]) begin
         run_frame(vecs[k].cw, vecs[k].syn, vecs[k].ok, vecs[k].data, vecs[k].gap, vecs[k].name);
      end

      // Hold: random traffic in IDLE must not disturb the last results.
      for (int i = 0; i < 20; i++) begin
         bit_valid = 1'($urandom_range(0, 1)); bit_in = 1'($urandom_range(0, 1)); tick();
         check("hold busy", busy, 0);
         check("hold done", done, 0);
         check("hold syndrome", syndrome, 9'h000);
         check("hold crc_ok", crc_ok, 1);
         check("hold data_out", data_out, 10'b1100000011);
      end

      // Restart after 7 bits of a corrupt frame, then a full valid frame.
      start = 1'b1; bit_valid = 1'b0; tick();
      start = 1'b0;
      shift_bits(19'b1111111111_111111111, 7, 0, "pre_restart");
      check("pre_restart no_done", done, 0);
      run_frame(19'b0000000001_100000011, 9'h000, 1'b1, 10'b0000000001, 0, "restart");

      // Reset after 12 bits discards the frame without a done.
      start = 1'b1; tick();
      start = 1'b0;
      shift_bits(19'b1010101010_101010101, 12, 0, "pre_reset");
      reset = 1'b1; bit_valid = 1'b1; tick();
      reset = 1'b0; bit_valid = 1'b0;
      check("midreset busy", busy, 0);
      check("midreset done", done, 0);
      check("midreset crc_ok", crc_ok, 0);
      check("midreset syndrome", syndrome, 0);
      check("midreset data_out", data_out, 0);
      busy_seen = 0;
      for (int i = 0; i < 25; i++) begin
         bit_valid = 1'b1; bit_in = 1'($urandom_range(0, 1)); tick();
         if (busy || done) busy_seen++;
      end
      check("after_reset idle", busy_seen, 0);

      // Random frames: half with valid CRC, half with one flipped bit.
      for (int n = 0; n < 40; n++) begin
         md = 10'($urandom);
         cw = {md, 9'h000};
         cw[8:0] = ref_mod(cw);
         if ($urandom_range(0, 1) == 1) cw[$urandom_range(0, 18)] ^= 1'b1;
         ms = ref_mod(cw);
         run_frame(cw, ms, (ms == 9'h000), cw[18:9], 2, "random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
